// File: rtl/ppu_pkg.sv
// Shared PPU table/attribute layout and address helpers for ppu_writer.
// Table selects, attribute field positions and the 16-bit PPU address format.
package ppu_pkg;

    typedef enum logic [1:0] {
        TBL_ATTR   = 2'd0,
        TBL_SPRITE = 2'd1,
        TBL_COLOR  = 2'd2,
        TBL_CLEAR  = 2'd3
    } tbl_e;

    localparam int ATTR_Y_LSB     = 0;
    localparam int ATTR_Y_MSB     = 9;
    localparam int ATTR_X_LSB     = 10;
    localparam int ATTR_X_MSB     = 19;
    localparam int ATTR_BASE_LSB  = 20;
    localparam int ATTR_BASE_MSB  = 27;
    localparam int ATTR_COLOR_LSB = 28;
    localparam int ATTR_COLOR_MSB = 31;

    localparam int ADDR_W       = 16;
    localparam int ADDR_PAD_W   = 6;
    localparam int ADDR_TBL_LSB = 8;
    localparam int ADDR_IDX_LSB = 0;

    typedef struct packed {
        tbl_e        tbl;
        logic [7:0]  idx;
        logic [31:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // ATTR and COLOR tables only have 16 entries
    function automatic logic [7:0] eff_idx(input tbl_e t, input logic [7:0] idx);
        return (t == TBL_ATTR || t == TBL_COLOR) ? {4'h0, idx[3:0]} : idx;
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input tbl_e t, input logic [7:0] idx);
        return {6'b0, t, idx};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO with full/empty flags and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
            if (do_push && !do_pop) cnt_q <= cnt_q + CNT_ONE;
            else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/ppu_writer.sv
// Buffered PPU bus master: replays table-write commands at one write per cycle.
// Define PPU_WRITER_VBLANK_EN to hold ATTR and CLEAR writes until vblank.
module ppu_writer
    import ppu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int SPRITE_ATTRS = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_table,
    input  logic [7:0]                    cmd_index,
    input  logic [31:0]                   cmd_data,
    input  logic                          vblank,
    output logic                          chipselect,
    output logic                          write,
    output logic [15:0]                   address,
    output logic [31:0]                   writedata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = (SPRITE_ATTRS > 1) ? $clog2(SPRITE_ATTRS) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(SPRITE_ATTRS - 1);
    localparam logic [CW-1:0] CLR_ONE  = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_q, cs_d;
    logic [15:0]   addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;

    cmd_t cmd_in, head;
    logic full, empty, push, pop;
    logic hold_head, hold_clr;

    assign cmd_in    = '{tbl: tbl_e'(cmd_table), idx: cmd_index, data: cmd_data};
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .din_i   (cmd_in),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

`ifdef PPU_WRITER_VBLANK_EN
    assign hold_clr  = !vblank;
    assign hold_head = !vblank && (head.tbl == TBL_ATTR || head.tbl == TBL_CLEAR);
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign hold_clr  = 1'b0;
    assign hold_head = 1'b0;
`endif

    // A CLEAR head issues n=0 on its pop edge; S_CLEAR covers n=1..last
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        addr_d  = addr_q;
        wd_d    = wd_q;
        pop     = 1'b0;
        case (state_q)
            S_CLEAR: begin
                if (!hold_clr) begin
                    cs_d   = 1'b1;
                    addr_d = mk_addr(TBL_ATTR, 8'(cnt_q));
                    wd_d   = '0;
                    if (cnt_q == CLR_LAST) state_d = S_ISSUE;
                    else cnt_d = cnt_q + CLR_ONE;
                end
            end
            default: begin
                if (!empty && !hold_head) begin
                    pop  = 1'b1;
                    cs_d = 1'b1;
                    if (head.tbl == TBL_CLEAR) begin
                        addr_d = mk_addr(TBL_ATTR, 8'h00);
                        wd_d   = '0;
                        cnt_d  = CLR_ONE;
                        state_d = (CLR_LAST == '0) ? S_ISSUE : S_CLEAR;
                    end else begin
                        addr_d  = mk_addr(head.tbl, eff_idx(head.tbl, head.idx));
                        wd_d    = head.data;
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    assign chipselect = cs_q;
    assign write      = cs_q;
    assign address    = addr_q;
    assign writedata  = wd_q;
    assign busy       = !empty || (state_q != S_IDLE);

endmodule
